// File: rtl/xh_cdb_pkg.sv
// Shared types and constants for the CDB TX REQ link layer.
// Holds the link state encoding and the REQ flit opcode field layout.
package xh_cdb_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_ACT   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DEACT = 2'd3
    } link_state_t;

    localparam int REQ_OPCODE_LSB = 14;
    localparam int REQ_OPCODE_W   = 7;

    typedef logic [REQ_OPCODE_W-1:0] req_opcode_t;

    localparam req_opcode_t LCRD_RETURN = '0;

endpackage

// File: rtl/xh_cdb_rr_arb.sv
// Round-robin picker: first asserted vld at or after ptr, wrapping modulo NREQ.
// Purely combinational; the caller owns the pointer register.
module xh_cdb_rr_arb #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] vld,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && vld[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/xh_cdb_req_arb.sv
// Shares one CHI TX REQ channel among NREQ requesters: LINKACTIVE handshake,
// L-credit accounting, round-robin grant, registered flit output, credit return.
module xh_cdb_req_arb
    import xh_cdb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int FLIT_W  = 127,
    parameter int MAX_CRD = 15,
    parameter int CRD_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   link_en,
    input  logic [NREQ-1:0]        req_vld,
    input  logic [NREQ*FLIT_W-1:0] req_flit,
    output logic [NREQ-1:0]        req_rdy,
    output logic                   tx_linkactivereq,
    input  logic                   tx_linkactiveack,
    output logic                   tx_flitpend,
    output logic                   tx_flitv,
    output logic [FLIT_W-1:0]      tx_flit,
    input  logic                   tx_lcrdv,
    output logic [CRD_W-1:0]       crd_cnt,
    output logic                   link_up,
    output logic                   crd_err
);

    localparam int PW = $clog2(NREQ);

    link_state_t       state_reg;
    logic              lar_reg;
    logic              link_up_reg;
    logic [CRD_W-1:0]  crd_cnt_reg;
    logic              crd_err_reg;
    logic [PW-1:0]     rr_ptr_reg;
    logic              flitv_reg;
    logic [FLIT_W-1:0] flit_reg;

    logic [FLIT_W-1:0] flit_arr [NREQ];
    logic [FLIT_W-1:0] ret_flit;
    logic [NREQ-1:0]   gnt;
    logic [PW-1:0]     gnt_idx;
    logic              any;
    logic              crd_avail;
    logic              arb_en;
    logic              grant;
    logic              ret;
    logic              send;
    logic              crd_in;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign flit_arr[gi] = req_flit[gi*FLIT_W +: FLIT_W];
        end
    endgenerate

    xh_cdb_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
        .vld     (req_vld),
        .ptr     (rr_ptr_reg),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        ret_flit = '0;
        ret_flit[REQ_OPCODE_LSB +: REQ_OPCODE_W] = LCRD_RETURN;
    end

    // A credit landing this cycle only counts at the edge, so it is never spendable same-cycle.
    assign crd_avail = (crd_cnt_reg != '0);
    assign arb_en    = (state_reg == ST_RUN) && crd_avail;
    assign grant     = arb_en && any;
    assign ret       = (state_reg == ST_DEACT) && crd_avail;
    assign send      = grant || ret;
    assign crd_in    = tx_lcrdv && (state_reg != ST_STOP);

    assign req_rdy          = arb_en ? gnt : '0;
    assign tx_flitpend      = (arb_en && (|req_vld)) || ret;
    assign tx_linkactivereq = lar_reg;
    assign link_up          = link_up_reg;
    assign tx_flitv         = flitv_reg;
    assign tx_flit          = flit_reg;
    assign crd_cnt          = crd_cnt_reg;
    assign crd_err          = crd_err_reg;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg   <= ST_STOP;
            lar_reg     <= 1'b0;
            link_up_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_STOP: if (link_en && !tx_linkactiveack) begin
                    state_reg <= ST_ACT;
                    lar_reg   <= 1'b1;
                end
                ST_ACT: if (tx_linkactiveack) begin
                    state_reg   <= ST_RUN;
                    link_up_reg <= 1'b1;
                end
                ST_RUN: if (!link_en) begin
                    state_reg   <= ST_DEACT;
                    lar_reg     <= 1'b0;
                    link_up_reg <= 1'b0;
                end
                ST_DEACT: if (!tx_linkactiveack && !crd_avail) begin
                    state_reg <= ST_STOP;
                end
                default: begin
                    state_reg   <= ST_STOP;
                    lar_reg     <= 1'b0;
                    link_up_reg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            crd_cnt_reg <= '0;
            crd_err_reg <= 1'b0;
            rr_ptr_reg  <= '0;
            flitv_reg   <= 1'b0;
            flit_reg    <= '0;
        end else begin
            if (crd_in && !send) begin
                if (crd_cnt_reg == CRD_W'(MAX_CRD)) begin
                    crd_err_reg <= 1'b1;
                end else begin
                    crd_cnt_reg <= crd_cnt_reg + 1'b1;
                end
            end else if (!crd_in && send) begin
                crd_cnt_reg <= crd_cnt_reg - 1'b1;
            end

            flitv_reg <= send;
            if (grant) begin
                flit_reg   <= flit_arr[gnt_idx];
                rr_ptr_reg <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (ret) begin
                flit_reg <= ret_flit;
            end
        end
    end

endmodule

// File: tb/tb_xh_cdb_req_arb.sv
// Directed bench for xh_cdb_req_arb: bring-up, fairness, starvation, overflow,
// deactivation credit return and asynchronous reset with a flit in flight.
module tb_xh_cdb_req_arb;

    localparam int NREQ   = 4;
    localparam int FLIT_W = 127;
    localparam int CRD_W  = 4;

    logic                   clk = 1'b0;
    logic                   rst_b;
    logic                   link_en;
    logic [NREQ-1:0]        req_vld;
    logic [NREQ*FLIT_W-1:0] req_flit;
    logic [NREQ-1:0]        req_rdy;
    logic                   tx_linkactivereq;
    logic                   tx_linkactiveack;
    logic                   tx_flitpend;
    logic                   tx_flitv;
    logic [FLIT_W-1:0]      tx_flit;
    logic                   tx_lcrdv;
    logic [CRD_W-1:0]       crd_cnt;
    logic                   link_up;
    logic                   crd_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    xh_cdb_req_arb #(.NREQ(NREQ), .FLIT_W(FLIT_W), .MAX_CRD(15), .CRD_W(CRD_W)) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .link_en          (link_en),
        .req_vld          (req_vld),
        .req_flit         (req_flit),
        .req_rdy          (req_rdy),
        .tx_linkactivereq (tx_linkactivereq),
        .tx_linkactiveack (tx_linkactiveack),
        .tx_flitpend      (tx_flitpend),
        .tx_flitv         (tx_flitv),
        .tx_flit          (tx_flit),
        .tx_lcrdv         (tx_lcrdv),
        .crd_cnt          (crd_cnt),
        .link_up          (link_up),
        .crd_err          (crd_err)
    );

    function automatic logic [FLIT_W-1:0] fv(input int i);
        logic [FLIT_W-1:0] v;
        v = '0;
        v[63:48] = 16'hC0DE;
        v[7:0]   = 8'(i + 1);
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (tx_flitv) $display("[TB] flit %0h crd_cnt=%0d", tx_flit, crd_cnt);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] exp_g;
        int order [5] = '{0, 1, 2, 3, 0};

        rst_b = 1'b0; link_en = 1'b0; req_vld = '0; tx_linkactiveack = 1'b0; tx_lcrdv = 1'b0;
        for (int i = 0; i < NREQ; i++) req_flit[i*FLIT_W +: FLIT_W] = fv(i);
        step(); step();
        check("rst_crd", 128'(crd_cnt), 128'(0));
        check("rst_lar", 128'(tx_linkactivereq), 128'(0));
        check("rst_up", 128'(link_up), 128'(0));
        check("rst_flitv", 128'(tx_flitv), 128'(0));
        check("rst_flit", 128'(tx_flit), 128'(0));
        check("rst_pend", 128'(tx_flitpend), 128'(0));
        check("rst_rdy", 128'(req_rdy), 128'(0));
        check("rst_err", 128'(crd_err), 128'(0));
        rst_b = 1'b1;

        // Bring-up: ack arrives three cycles after the request.
        link_en = 1'b1;
        step();
        check("act_lar", 128'(tx_linkactivereq), 128'(1));
        for (int i = 0; i < 2; i++) begin
            step();
            check("act_up", 128'(link_up), 128'(0));
            check("act_flitv", 128'(tx_flitv), 128'(0));
        end
        tx_linkactiveack = 1'b1;
        step();
        check("run_up", 128'(link_up), 128'(1));
        check("run_lar", 128'(tx_linkactivereq), 128'(1));
        tx_lcrdv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bring_flitv", 128'(tx_flitv), 128'(0));
        end
        tx_lcrdv = 1'b0;
        check("bring_crd", 128'(crd_cnt), 128'(4));

        // Fairness with steady credit refill.
        req_vld = 4'b1111; tx_lcrdv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_g = NREQ'(1) << order[i];
            #1;
            check("fair_rdy", 128'(req_rdy), 128'(exp_g));
            check("fair_pend", 128'(tx_flitpend), 128'(1));
            step();
            check("fair_flitv", 128'(tx_flitv), 128'(1));
            check("fair_flit", 128'(tx_flit), 128'(fv(order[i])));
            check("fair_crd", 128'(crd_cnt), 128'(4));
        end
        req_vld = '0; tx_lcrdv = 1'b0;
        step();
        check("idle_flitv", 128'(tx_flitv), 128'(0));
        check("idle_hold", 128'(tx_flit), 128'(fv(0)));

        // Spend two credits on requester 1, then starve requester 0.
        req_vld = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("drain_rdy", 128'(req_rdy), 128'(4'b0010));
            step();
            check("drain_flit", 128'(tx_flit), 128'(fv(1)));
        end
        check("starve_crd0", 128'(crd_cnt), 128'(2));
        req_vld = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("starve_rdy", 128'(req_rdy), 128'(4'b0001));
            step();
            check("starve_flitv", 128'(tx_flitv), 128'(1));
            check("starve_flit", 128'(tx_flit), 128'(fv(0)));
        end
        #1;
        check("starve_rdy0", 128'(req_rdy), 128'(0));
        check("starve_pend0", 128'(tx_flitpend), 128'(0));
        step();
        check("starve_noflit", 128'(tx_flitv), 128'(0));
        check("starve_crd", 128'(crd_cnt), 128'(0));
        tx_lcrdv = 1'b1;
        #1;
        check("samecyc_rdy", 128'(req_rdy), 128'(0));
        step();
        tx_lcrdv = 1'b0;
        check("refill_flitv", 128'(tx_flitv), 128'(0));
        check("refill_crd", 128'(crd_cnt), 128'(1));
        #1;
        check("refill_rdy", 128'(req_rdy), 128'(4'b0001));
        step();
        check("third_flitv", 128'(tx_flitv), 128'(1));
        check("third_flit", 128'(tx_flit), 128'(fv(0)));
        check("third_crd", 128'(crd_cnt), 128'(0));
        req_vld = '0;

        // Overflow: sixteenth credit with no send.
        tx_lcrdv = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("ovf_crd15", 128'(crd_cnt), 128'(15));
        check("ovf_err0", 128'(crd_err), 128'(0));
        step();
        check("ovf_crd", 128'(crd_cnt), 128'(15));
        check("ovf_err", 128'(crd_err), 128'(1));
        tx_lcrdv = 1'b0;
        step();
        check("ovf_sticky", 128'(crd_err), 128'(1));

        // Drain to three credits, then deactivate.
        req_vld = 4'b0001;
        for (int i = 0; i < 12; i++) step();
        check("pre_deact_crd", 128'(crd_cnt), 128'(3));
        req_vld = '0; link_en = 1'b0;
        step();
        check("deact_lar", 128'(tx_linkactivereq), 128'(0));
        check("deact_up", 128'(link_up), 128'(0));
        check("deact_flitv0", 128'(tx_flitv), 128'(0));
        req_vld = 4'b1111;
        #1;
        check("deact_rdy", 128'(req_rdy), 128'(0));
        check("deact_pend", 128'(tx_flitpend), 128'(1));
        for (int i = 0; i < 3; i++) begin
            step();
            check("ret_flitv", 128'(tx_flitv), 128'(1));
            check("ret_flit", 128'(tx_flit), 128'(0));
            check("ret_crd", 128'(crd_cnt), 128'(2 - i));
        end
        check("ret_pend0", 128'(tx_flitpend), 128'(0));
        step();
        check("ret_done", 128'(tx_flitv), 128'(0));
        req_vld = '0; tx_linkactiveack = 1'b0;
        step();
        tx_lcrdv = 1'b1;
        step();
        tx_lcrdv = 1'b0;
        check("stop_ignore_crd", 128'(crd_cnt), 128'(0));
        check("stop_lar", 128'(tx_linkactivereq), 128'(0));

        // Async reset between grant and flitv.
        link_en = 1'b1;
        step();
        check("re_act_lar", 128'(tx_linkactivereq), 128'(1));
        tx_linkactiveack = 1'b1;
        step();
        tx_lcrdv = 1'b1;
        step(); step();
        tx_lcrdv = 1'b0;
        check("re_crd", 128'(crd_cnt), 128'(2));
        req_vld = 4'b0001;
        #1;
        check("re_rdy", 128'(req_rdy), 128'(4'b0001));
        #1;
        rst_b = 1'b0;
        #1;
        check("arst_rdy", 128'(req_rdy), 128'(0));
        check("arst_pend", 128'(tx_flitpend), 128'(0));
        check("arst_crd", 128'(crd_cnt), 128'(0));
        check("arst_up", 128'(link_up), 128'(0));
        check("arst_lar", 128'(tx_linkactivereq), 128'(0));
        check("arst_flitv", 128'(tx_flitv), 128'(0));
        link_en = 1'b0; req_vld = '0; tx_linkactiveack = 1'b0;
        step();
        check("arst_flitv1", 128'(tx_flitv), 128'(0));
        check("arst_flit", 128'(tx_flit), 128'(0));
        rst_b = 1'b1;
        step();
        check("post_flitv", 128'(tx_flitv), 128'(0));
        check("post_crd", 128'(crd_cnt), 128'(0));
        check("post_err", 128'(crd_err), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
